axilite_slave_regs: RTL and testbench

- AXI-Lite slave register file; consumes a slave-side AXI-Lite bundle and exposes NUM_REGS read/write control registers to the surrounding logic.
- Sits directly downstream of the AXI-Lite interface, connected to its slave view, one instance per peripheral block.
- Independent write-address and write-data acceptance; single outstanding write and single outstanding read.

---
 rtl/axilite_slave_regs_if.sv | 34 +++
 rtl/axilite_slave_regs.sv | 175 +++++++++++++++++
 tb/tb_axilite_slave_regs.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/axilite_slave_regs_if.sv
// AXI-Lite bus bundle shared by the register-file slave and whatever masters it.
// The slave modport is what axilite_slave_regs consumes; master is the mirror view.
interface axilite_slave_regs_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axilite_slave_regs.sv
// AXI-Lite slave exposing NUM_REGS read/write control registers with per-register write pulses.
// Define AXILITE_SLV_DECERR_EN to answer out-of-range accesses with DECERR instead of OKAY.
module axilite_slave_regs #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  axilite_slave_regs_if.slave            bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXILITE_SLV_DECERR_EN
  localparam logic [1:0] RESP_OOR = 2'b11;
`else
  localparam logic [1:0] RESP_OOR = 2'b00;
`endif

  typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wr_state_t;
  typedef enum logic       {RD_IDLE, RD_RESP}          rd_state_t;

  wr_state_t               wr_state_reg;
  rd_state_t               rd_state_reg;
  logic [DATA_WIDTH-1:0]   regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0]     wr_pulse_reg;
  logic                    aw_held_reg, w_held_reg;
  logic                    awready_reg, wready_reg, arready_reg;
  logic [IDX_W-1:0]        aw_idx_reg;
  logic [DATA_WIDTH-1:0]   w_data_reg;
  logic [STRB_W-1:0]       w_strb_reg;
  logic                    bvalid_reg, rvalid_reg;
  logic [1:0]              bresp_reg, rresp_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;

  logic                    aw_held_next, w_held_next;
  logic [NUM_REGS-1:0]     aw_sel;
  logic                    aw_in_range;
  logic [IDX_W-1:0]        ar_idx;
  logic [DATA_WIDTH-1:0]   rd_mux;
  logic                    ar_in_range;

  assign aw_held_next = aw_held_reg | (bus.awvalid & awready_reg);
  assign w_held_next  = w_held_reg  | (bus.wvalid  & wready_reg);
  assign ar_idx       = bus.araddr[ADDR_WIDTH-1:2];

  // Decoding by compare loop keeps out-of-range indices from ever addressing the array.
  always_comb begin
    aw_sel      = '0;
    rd_mux      = '0;
    ar_in_range = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      aw_sel[k] = (aw_idx_reg == IDX_W'(k));
      if (ar_idx == IDX_W'(k)) begin
        rd_mux      = regs_reg[k];
        ar_in_range = 1'b1;
      end
    end
    aw_in_range = |aw_sel;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_reg <= WR_IDLE;
      for (int k = 0; k < NUM_REGS; k++) regs_reg[k] <= '0;
      wr_pulse_reg <= '0;
      aw_held_reg  <= 1'b0;
      w_held_reg   <= 1'b0;
      awready_reg  <= 1'b0;
      wready_reg   <= 1'b0;
      aw_idx_reg   <= '0;
      w_data_reg   <= '0;
      w_strb_reg   <= '0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
    end else begin
      wr_pulse_reg <= '0;
      case (wr_state_reg)
        WR_IDLE: begin
          if (bus.awvalid && awready_reg) aw_idx_reg <= bus.awaddr[ADDR_WIDTH-1:2];
          if (bus.wvalid && wready_reg) begin
            w_data_reg <= bus.wdata;
            w_strb_reg <= bus.wstrb;
          end
          aw_held_reg <= aw_held_next;
          w_held_reg  <= w_held_next;
          if (aw_held_next && w_held_next) begin
            wr_state_reg <= WR_EXEC;
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
          end else begin
            awready_reg <= !aw_held_next;
            wready_reg  <= !w_held_next;
          end
        end
        WR_EXEC: begin
          for (int k = 0; k < NUM_REGS; k++) begin
            if (aw_sel[k]) begin
              wr_pulse_reg[k] <= 1'b1;
              for (int b = 0; b < STRB_W; b++) begin
                if (w_strb_reg[b]) regs_reg[k][8*b +: 8] <= w_data_reg[8*b +: 8];
              end
            end
          end
          bvalid_reg   <= 1'b1;
          bresp_reg    <= aw_in_range ? RESP_OKAY : RESP_OOR;
          wr_state_reg <= WR_RESP;
        end
        WR_RESP: begin
          if (bus.bready) begin
            bvalid_reg   <= 1'b0;
            aw_held_reg  <= 1'b0;
            w_held_reg   <= 1'b0;
            awready_reg  <= 1'b1;
            wready_reg   <= 1'b1;
            wr_state_reg <= WR_IDLE;
          end
        end
        default: wr_state_reg <= WR_IDLE;
      endcase
    end
  end

  // Read sees pre-commit register contents when it lands on the same edge as a write.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state_reg <= RD_IDLE;
      arready_reg  <= 1'b0;
      rvalid_reg   <= 1'b0;
      rresp_reg    <= RESP_OKAY;
      rdata_reg    <= '0;
    end else begin
      case (rd_state_reg)
        RD_IDLE: begin
          if (bus.arvalid && arready_reg) begin
            rdata_reg    <= rd_mux;
            rresp_reg    <= ar_in_range ? RESP_OKAY : RESP_OOR;
            rvalid_reg   <= 1'b1;
            arready_reg  <= 1'b0;
            rd_state_reg <= RD_RESP;
          end else begin
            arready_reg <= 1'b1;
          end
        end
        RD_RESP: begin
          if (bus.rready) begin
            rvalid_reg   <= 1'b0;
            arready_reg  <= 1'b1;
            rd_state_reg <= RD_IDLE;
          end
        end
        default: rd_state_reg <= RD_IDLE;
      endcase
    end
  end

  assign bus.awready = awready_reg;
  assign bus.wready  = wready_reg;
  assign bus.bvalid  = bvalid_reg;
  assign bus.bresp   = bresp_reg;
  assign bus.arready = arready_reg;
  assign bus.rvalid  = rvalid_reg;
  assign bus.rresp   = rresp_reg;
  assign bus.rdata   = rdata_reg;
  assign wr_pulse    = wr_pulse_reg;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
    assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = regs_reg[gi];
  end

endmodule

// File: tb/tb_axilite_slave_regs.sv
// Directed bench for axilite_slave_regs: write ordering, backpressure, reads, same-edge hazard,
// out-of-range access and reset discard. Honors AXILITE_SLV_DECERR_EN for expected responses.
module tb_axilite_slave_regs;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NR = 16;
`ifdef AXILITE_SLV_DECERR_EN
  localparam logic [1:0] EXP_OOR = 2'b11;
`else
  localparam logic [1:0] EXP_OOR = 2'b00;
`endif

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [NR*DW-1:0]  reg_out;
  logic [NR-1:0]     wr_pulse;
  logic [NR*DW-1:0]  exp_all;
  int                compared = 0;
  int                mismatched = 0;

  axilite_slave_regs_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axilite_slave_regs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .bus      (bus),
    .reg_out  (reg_out),
    .wr_pulse (wr_pulse)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  initial begin
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    exp_all = '0;

    // Reset state
    repeat (2) tick();
    check("rst_awready", bus.awready, 0);
    check("rst_wready", bus.wready, 0);
    check("rst_arready", bus.arready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_regs", reg_out, exp_all);
    check("rst_pulse", wr_pulse, 0);
    aresetn = 1'b1;
    tick();
    check("post_rst_awready", bus.awready, 1);
    check("post_rst_wready", bus.wready, 1);
    check("post_rst_arready", bus.arready, 1);

    // AW and W in the same cycle to reg1
    bus.awaddr = 8'h04; bus.awvalid = 1'b1;
    bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("w1_awready_drop", bus.awready, 0);
    check("w1_wready_drop", bus.wready, 0);
    check("w1_bvalid_early", bus.bvalid, 0);
    check("w1_regs_early", reg_out, exp_all);
    tick();
    exp_all[1*DW +: DW] = 32'hDEADBEEF;
    check("w1_bvalid", bus.bvalid, 1);
    check("w1_bresp", bus.bresp, 2'b00);
    check("w1_regs", reg_out, exp_all);
    check("w1_pulse", wr_pulse, 16'h0002);

    // B backpressure while a second AW is offered
    bus.awaddr = 8'h08; bus.awvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_bvalid", bus.bvalid, 1);
      check("bp_awready", bus.awready, 0);
      check("bp_wready", bus.wready, 0);
      check("bp_pulse", wr_pulse, 0);
    end
    bus.bready = 1'b1;
    tick();
    check("bhs_bvalid", bus.bvalid, 0);
    check("bhs_awready", bus.awready, 1);
    check("bhs_wready", bus.wready, 1);
    tick();
    bus.awvalid = 1'b0; bus.bready = 1'b0;
    check("aw2_awready", bus.awready, 0);
    check("aw2_wready", bus.wready, 1);

    // W arrives three cycles after AW
    for (int i = 0; i < 3; i++) begin
      tick();
      check("aw2_wait_awready", bus.awready, 0);
      check("aw2_wait_bvalid", bus.bvalid, 0);
    end
    bus.wdata = 32'h12345678; bus.wstrb = 4'b0101; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    check("w2_wready_drop", bus.wready, 0);
    check("w2_bvalid_early", bus.bvalid, 0);
    tick();
    exp_all[2*DW +: DW] = 32'h00340078;
    check("w2_regs", reg_out, exp_all);
    check("w2_bvalid", bus.bvalid, 1);
    check("w2_bresp", bus.bresp, 2'b00);
    check("w2_pulse", wr_pulse, 16'h0004);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("w2_bdone", bus.bvalid, 0);

    // Read reg1 with R backpressure
    bus.araddr = 8'h04; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    check("r1_rvalid", bus.rvalid, 1);
    check("r1_rdata", bus.rdata, 32'hDEADBEEF);
    check("r1_rresp", bus.rresp, 2'b00);
    check("r1_arready", bus.arready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("r1_hold_rvalid", bus.rvalid, 1);
      check("r1_hold_rdata", bus.rdata, 32'hDEADBEEF);
      check("r1_hold_arready", bus.arready, 0);
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check("r1_done_rvalid", bus.rvalid, 0);
    check("r1_done_arready", bus.arready, 1);

    // Read of reg3 on the same edge as its write commit
    bus.awaddr = 8'h0C; bus.awvalid = 1'b1;
    bus.wdata = 32'hA5A5A5A5; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 8'h0C; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    exp_all[3*DW +: DW] = 32'hA5A5A5A5;
    check("hz_rvalid", bus.rvalid, 1);
    check("hz_rdata_old", bus.rdata, 0);
    check("hz_bvalid", bus.bvalid, 1);
    check("hz_regs", reg_out, exp_all);
    check("hz_pulse", wr_pulse, 16'h0008);
    bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0; bus.rready = 1'b0;
    check("hz_bdone", bus.bvalid, 0);
    check("hz_rdone", bus.rvalid, 0);
    bus.araddr = 8'h0C; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    check("hz_reread", bus.rdata, 32'hA5A5A5A5);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;

    // Out-of-range write and read at 0xFC
    bus.awaddr = 8'hFC; bus.awvalid = 1'b1;
    bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    check("oor_bvalid", bus.bvalid, 1);
    check("oor_bresp", bus.bresp, EXP_OOR);
    check("oor_pulse", wr_pulse, 0);
    check("oor_regs", reg_out, exp_all);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    bus.araddr = 8'hFC; bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    check("oor_rvalid", bus.rvalid, 1);
    check("oor_rdata", bus.rdata, 0);
    check("oor_rresp", bus.rresp, EXP_OOR);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check("oor_rdone", bus.rvalid, 0);

    // Reset with an AW held: the held address must be discarded
    bus.awaddr = 8'h04; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    aresetn = 1'b0;
    tick();
    exp_all = '0;
    check("mid_rst_awready", bus.awready, 0);
    check("mid_rst_regs", reg_out, exp_all);
    aresetn = 1'b1;
    bus.wdata = 32'h11111111; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    tick();
    bus.wvalid = 1'b0;
    tick();
    check("mid_rst_bvalid", bus.bvalid, 0);
    check("mid_rst_regs_after", reg_out, exp_all);
    check("mid_rst_awready_after", bus.awready, 1);
    check("mid_rst_wready_after", bus.wready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
